// File: rtl/boot_loader.sv
// Byte-stream boot loader: receives a length-prefixed program image,
// writes it into instruction memory and releases the core on a good checksum.
module boot_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              error,
   output logic [15:0]       word_count
);

   localparam logic [2:0] LEN_HI = 3'd0;
   localparam logic [2:0] LEN_LO = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] CHECK  = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
   localparam logic [2:0] ERR    = 3'd5;

   logic [2:0]      state;
   logic [31:0]     asm_q;
   logic [1:0]      bcnt;
   logic [ADDR_W:0] widx;
   logic [7:0]      csum;
   logic            accept;
   logic [15:0]     len;
   logic [16:0]     nxt_idx;
   logic            last_word;

   assign in_ready = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == DATA)   || (state == CHECK);
   assign accept    = in_valid && in_ready;
   assign len       = {word_count[15:8], in_data};
   assign nxt_idx   = 17'(widx) + 17'd1;
   assign last_word = (nxt_idx == {1'b0, word_count});
   // The assembly register holds the finished word during its write cycle
   assign imem_wdata = asm_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= LEN_HI;
         asm_q      <= '0;
         bcnt       <= '0;
         widx       <= '0;
         csum       <= '0;
         word_count <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         core_rst   <= 1'b1;
      end else begin
         imem_we  <= 1'b0;
         done     <= (state == DONE);
         error    <= (state == ERR);
         core_rst <= (state != DONE);
         if (accept) begin
            case (state)
               LEN_HI: begin
                  word_count[15:8] <= in_data;
                  state            <= LEN_LO;
               end
               LEN_LO: begin
                  word_count[7:0] <= in_data;
                  if (17'(len) > (17'd1 << ADDR_W))
                     state <= ERR;
                  else if (len == 16'd0)
                     state <= CHECK;
                  else
                     state <= DATA;
               end
               DATA: begin
                  asm_q <= {asm_q[23:0], in_data};
                  csum  <= csum ^ in_data;
                  bcnt  <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
                     imem_we   <= 1'b1;
                     imem_addr <= widx[ADDR_W-1:0];
                     widx      <= nxt_idx[ADDR_W:0];
                     if (last_word)
                        state <= CHECK;
                  end
               end
               CHECK: begin
                  state <= (in_data == csum) ? DONE : ERR;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: one task per scenario,
// writes captured by a monitor and compared to hand-computed values.
module tb_boot_loader;

   localparam int ADDR_W = 8;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic              error;
   logic [15:0]       word_count;

   int n_cmp = 0;
   int n_bad = 0;
   int long_cnt = 0;
   logic prev_we = 1'b0;
   logic [ADDR_W-1:0] wa[$];
   logic [31:0]       wd[$];

   boot_loader #(.ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RST(RST),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_rst(core_rst),
      .done(done), .error(error), .word_count(word_count)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (imem_we) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
      end
      if (imem_we && prev_we) long_cnt++;
      prev_we = imem_we;
   end

   task automatic do_reset();
      RST = 1'b1;
      in_valid = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      wa.delete();
      wd.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      in_valid = 1'b1;
      in_data = b;
      @(negedge CLK);
      in_valid = 1'b0;
      in_data = 8'hxx;
      repeat (gap) @(negedge CLK);
   endtask

   // Data bytes XOR to 0x89
   task automatic send_std(input logic [7:0] ck, input int gap);
      logic [7:0] s [10];
      s = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00,
            8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
      for (int i = 0; i < 10; i++) send_byte(s[i], gap);
      send_byte(ck, gap);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      n_cmp++;
      if ({imem_we, done, error, core_rst} !== 4'b0001) begin
         $display("FAIL reset_flags got %b want 0001",
                  {imem_we, done, error, core_rst});
         n_bad++;
      end
      n_cmp++;
      if ({word_count, 8'(imem_addr), imem_wdata} !== 56'd0) begin
         $display("FAIL reset_regs got %h/%h/%h want 0",
                  word_count, imem_addr, imem_wdata);
         n_bad++;
      end
      RST = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_ready got %b want 1", in_ready);
         n_bad++;
      end
   endtask

   task automatic check_std_writes(input string nm);
      n_cmp++;
      if (wa.size() !== 2 || wa[0] !== 8'h00 || wd[0] !== 32'h20010005 ||
          wa[1] !== 8'h01 || wd[1] !== 32'hAC010000) begin
         $display("FAIL %s_writes got n=%0d %h:%h %h:%h want 2 00:20010005 01:AC010000",
                  nm, wa.size(), wa[0], wd[0], wa[1], wd[1]);
         n_bad++;
      end
   endtask

   task automatic test_good_load();
      do_reset();
      send_std(8'h89, 0);
      n_cmp++;
      if (done !== 1'b0) begin
         $display("FAIL good_latency done got %b want 0", done);
         n_bad++;
      end
      @(negedge CLK);
      check_std_writes("good");
      n_cmp++;
      if ({done, error, core_rst, in_ready} !== 4'b1000) begin
         $display("FAIL good_flags got %b want 1000",
                  {done, error, core_rst, in_ready});
         n_bad++;
      end
      n_cmp++;
      if (word_count !== 16'd2) begin
         $display("FAIL good_wcount got %0d want 2", word_count);
         n_bad++;
      end
   endtask

   task automatic test_zero_len();
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(negedge CLK);
      n_cmp++;
      if (wa.size() !== 0 || done !== 1'b1 || core_rst !== 1'b0) begin
         $display("FAIL zero_good got n=%0d done=%b rst=%b want 0 1 0",
                  wa.size(), done, core_rst);
         n_bad++;
      end
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      @(negedge CLK);
      n_cmp++;
      if ({done, error, core_rst} !== 3'b011) begin
         $display("FAIL zero_bad got %b want 011",
                  {done, error, core_rst});
         n_bad++;
      end
   endtask

   task automatic test_bad_checksum();
      do_reset();
      send_std(8'h8C, 0);
      @(negedge CLK);
      check_std_writes("badck");
      n_cmp++;
      if ({done, error, core_rst, in_ready} !== 4'b0110) begin
         $display("FAIL badck_flags got %b want 0110",
                  {done, error, core_rst, in_ready});
         n_bad++;
      end
   endtask

   task automatic test_oversize();
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         $display("FAIL over_ready got %b want 0", in_ready);
         n_bad++;
      end
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      n_cmp++;
      if (wa.size() !== 0 || error !== 1'b1 || word_count !== 16'h0101) begin
         $display("FAIL over_state got n=%0d err=%b wc=%h want 0 1 0101",
                  wa.size(), error, word_count);
         n_bad++;
      end
   endtask

   task automatic test_max_len();
      logic [31:0] w;
      logic [7:0]  ck;
      int          bad_words;
      do_reset();
      ck = 8'h00;
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 256; i++) begin
         w = {8'(i), 8'hA5, ~8'(i), 8'h3C};
         for (int k = 3; k >= 0; k--) begin
            ck = ck ^ w[k*8 +: 8];
            send_byte(w[k*8 +: 8], 0);
         end
      end
      send_byte(ck, 0);
      @(negedge CLK);
      n_cmp++;
      if (wa.size() !== 256) begin
         $display("FAIL max_count got %0d want 256", wa.size());
         n_bad++;
      end
      bad_words = 0;
      for (int i = 0; i < wa.size() && i < 256; i++) begin
         w = {8'(i), 8'hA5, ~8'(i), 8'h3C};
         if (wa[i] !== 8'(i) || wd[i] !== w) bad_words++;
      end
      n_cmp++;
      if (bad_words !== 0) begin
         $display("FAIL max_words got %0d bad want 0", bad_words);
         n_bad++;
      end
      n_cmp++;
      if (wa[255] !== 8'hFF || wd[255] !== 32'hFFA5003C) begin
         $display("FAIL max_last got %h:%h want FF:FFA5003C",
                  wa[255], wd[255]);
         n_bad++;
      end
      n_cmp++;
      if (done !== 1'b1 || word_count !== 16'h0100) begin
         $display("FAIL max_done got %b wc=%h want 1 0100",
                  done, word_count);
         n_bad++;
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] s [7];
      s = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC};
      do_reset();
      for (int i = 0; i < 7; i++) send_byte(s[i], 0);
      n_cmp++;
      if (wa.size() !== 1 || wd[0] !== 32'h20010005) begin
         $display("FAIL mid_first got n=%0d %h want 1 20010005",
                  wa.size(), wd[0]);
         n_bad++;
      end
      do_reset();
      n_cmp++;
      if (word_count !== 16'd0 || in_ready !== 1'b1) begin
         $display("FAIL mid_clear got wc=%h rdy=%b want 0 1",
                  word_count, in_ready);
         n_bad++;
      end
      send_std(8'h89, 0);
      @(negedge CLK);
      check_std_writes("mid");
      n_cmp++;
      if (done !== 1'b1) begin
         $display("FAIL mid_done got %b want 1", done);
         n_bad++;
      end
   endtask

   task automatic test_gaps();
      long_cnt = 0;
      do_reset();
      send_std(8'h89, 3);
      check_std_writes("gap");
      n_cmp++;
      if ({done, core_rst, word_count} !== {2'b10, 16'd2}) begin
         $display("FAIL gap_done got %b %b %0d want 1 0 2",
                  done, core_rst, word_count);
         n_bad++;
      end
      n_cmp++;
      if (long_cnt !== 0) begin
         $display("FAIL gap_pulse got %0d long strobes want 0", long_cnt);
         n_bad++;
      end
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_zero_len();
      test_bad_checksum();
      test_oversize();
      test_max_len();
      test_mid_reset();
      test_gaps();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
